// File: rtl/cordic_vectoring_iterative_pkg.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_iterative_pkg
// Shared constants for the iterative vectoring-mode CORDIC:
//   - default iteration count
//   - arctangent table in units of pi/128 (truncated)
//   - FSM state encodings
//   - pre-rotation angle (pi/2 = 64 units)
//   - gain-compensation shift set (1/2 + 1/8 - 1/64 - 1/512 ~= 1/K)
// -----------------------------------------------------------------------------
package cordic_vectoring_iterative_pkg;

  localparam int CORDIC_ITERATIONS = 6;

  // pi/2 expressed in pi/128 angle units
  localparam int PREROT_ANGLE = 64;

  // Gain compensation: x*(2^-1 + 2^-3 - 2^-6 - 2^-9)
  localparam int COMP_SH_A = 1;
  localparam int COMP_SH_B = 3;
  localparam int COMP_SH_C = 6;
  localparam int COMP_SH_D = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREROT = 3'd1,
    ST_CALC   = 3'd2,
    ST_COMP   = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

  // atan(2^-i) in units of pi/128, truncated toward zero
  function automatic int atan_lut(input int i);
    case (i)
      0:       return 32;
      1:       return 18;
      2:       return 9;
      3:       return 5;
      4:       return 2;
      5:       return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vectoring_slice.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_slice
// One combinational vectoring micro-rotation. Direction is chosen from the
// sign of y so that y is driven toward zero; both updates use the incoming
// (pre-update) x and y.
// Ports:
//   x_i, y_i     signed W-bit vector components
//   z_i          signed Z_W-bit accumulated angle
//   shift_i      iteration index i (arithmetic right-shift amount)
//   angle_i      atan(2^-i) in angle units
//   x_o, y_o, z_o  rotated vector and updated angle
// -----------------------------------------------------------------------------
module cordic_vectoring_slice #(
  parameter int W    = 10,
  parameter int Z_W  = 8,
  parameter int SH_W = 3
) (
  input  logic signed [W-1:0]   x_i,
  input  logic signed [W-1:0]   y_i,
  input  logic signed [Z_W-1:0] z_i,
  input  logic        [SH_W-1:0] shift_i,
  input  logic signed [Z_W-1:0] angle_i,
  output logic signed [W-1:0]   x_o,
  output logic signed [W-1:0]   y_o,
  output logic signed [Z_W-1:0] z_o
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (!y_i[W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + angle_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - angle_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iterative.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_iterative
// Iterative vectoring-mode CORDIC: converts a Q1.7 Cartesian vector (x, y)
// into magnitude (Q3.7) and phase (pi/128 units, wrapping two's complement).
// One micro-rotation slice is reused once per cycle under FSM control.
// Optional build macro: CORDIC_GAIN_COMP_EN adds a COMP state that scales the
// magnitude by ~1/K (0.6074) so mag_o is |v|; otherwise mag_o carries K~1.6465.
// Ports:
//   clk_i                    clock, rising edge
//   rst_i                    asynchronous active-high reset
//   x_i, y_i                 signed Q1.7 input components
//   data_in_valid_strobe_i   one-cycle input-valid pulse (ignored when busy)
//   mag_o                    signed Q3.7 magnitude (>= 0), held until next result
//   z_o                      signed angle, LSB = pi/128, -128 = -pi
//   busy_o                   high from accept edge until result is registered
//   data_out_valid_strobe_o  one-cycle result-valid pulse
// -----------------------------------------------------------------------------
module cordic_vectoring_iterative
  import cordic_vectoring_iterative_pkg::*;
#(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = CORDIC_ITERATIONS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic                     data_in_valid_strobe_i,
  output logic signed [N_FRAC+2:0] mag_o,
  output logic signed [N_FRAC:0]   z_o,
  output logic                     busy_o,
  output logic                     data_out_valid_strobe_o
);

  localparam int W     = N_FRAC + 3;
  localparam int Z_W   = N_FRAC + 1;
  localparam int CNT_W = (ITERATIONS > 2) ? $clog2(ITERATIONS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(ITERATIONS - 1);
  localparam logic signed [Z_W-1:0] PREROT_POS = Z_W'(PREROT_ANGLE);
  localparam logic signed [Z_W-1:0] PREROT_NEG = Z_W'(-PREROT_ANGLE);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [Z_W-1:0] z_q, z_d;
  logic                zero_q, zero_d;
  logic signed [W-1:0] mag_q, mag_d;
  logic signed [Z_W-1:0] zout_q, zout_d;
  logic                busy_q, busy_d;
  logic                vld_q, vld_d;

  logic signed [W-1:0]   x_ext, y_ext;
  logic signed [Z_W-1:0] angle;
  logic signed [W-1:0]   sl_x, sl_y;
  logic signed [Z_W-1:0] sl_z;

`ifdef CORDIC_GAIN_COMP_EN
  // Shift-add approximation of 1/K, each term truncated
  function automatic logic signed [W-1:0] gain_comp(input logic signed [W-1:0] v);
    return (v >>> COMP_SH_A) + (v >>> COMP_SH_B) - (v >>> COMP_SH_C) - (v >>> COMP_SH_D);
  endfunction
`endif

  // Q1.7 -> Q3.7 sign extension leaves headroom for the K gain and for
  // negating -1.0 during pre-rotation.
  assign x_ext = {{(W-N_FRAC-1){x_i[N_FRAC]}}, x_i};
  assign y_ext = {{(W-N_FRAC-1){y_i[N_FRAC]}}, y_i};
  assign angle = Z_W'(atan_lut(int'(cnt_q)));

  cordic_vectoring_slice #(
    .W    (W),
    .Z_W  (Z_W),
    .SH_W (CNT_W)
  ) u_slice (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .angle_i (angle),
    .x_o     (sl_x),
    .y_o     (sl_y),
    .z_o     (sl_z)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    zout_d  = zout_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_in_valid_strobe_i) begin
          x_d     = x_ext;
          y_d     = y_ext;
          z_d     = '0;
          zero_d  = (x_i == '0) && (y_i == '0);
          busy_d  = 1'b1;
          state_d = ST_PREROT;
        end
      end
      ST_PREROT: begin
        // Fold left half-plane vectors into the right half-plane by +/-pi/2
        // so the micro-rotations only have to cover +/-pi/2.
        if (x_q[W-1] && !y_q[W-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = PREROT_POS;
        end else if (x_q[W-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = PREROT_NEG;
        end else begin
          z_d = '0;
        end
        cnt_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        x_d = sl_x;
        y_d = sl_y;
        z_d = sl_z;
        if (cnt_q == CNT_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = ST_COMP;
`else
          state_d = ST_OUTPUT;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_COMP: begin
        x_d     = gain_comp(x_q);
        state_d = ST_OUTPUT;
      end
`endif
      ST_OUTPUT: begin
        mag_d   = x_q;
        // Zero vector has no defined phase; report 0 instead of the
        // accumulated table sum.
        zout_d  = zero_q ? '0 : z_q;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      zout_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      zout_q  <= zout_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign mag_o                   = mag_q;
  assign z_o                     = zout_q;
  assign busy_o                  = busy_q;
  assign data_out_valid_strobe_o = vld_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// -----------------------------------------------------------------------------
// tb_cordic_vectoring_iterative
// Directed bench for the iterative vectoring CORDIC. Expected magnitudes and
// angles are hand-iterated through the six truncated micro-rotations.
// Honours CORDIC_GAIN_COMP_EN (compensated magnitude, one extra cycle).
// -----------------------------------------------------------------------------
module tb_cordic_vectoring_iterative;

`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP = 1'b1;
  localparam int LAT  = 9;
`else
  localparam bit COMP = 1'b0;
  localparam int LAT  = 8;
`endif

  logic              clk;
  logic              rst;
  logic signed [7:0] x_in;
  logic signed [7:0] y_in;
  logic              stb_in;
  logic signed [9:0] mag;
  logic signed [7:0] z;
  logic              busy;
  logic              vld;

  int n_checks;
  int n_pass;

  cordic_vectoring_iterative dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .x_i                     (x_in),
    .y_i                     (y_in),
    .data_in_valid_strobe_i  (stb_in),
    .mag_o                   (mag),
    .z_o                     (z),
    .busy_o                  (busy),
    .data_out_valid_strobe_o (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Launch one job and check busy, latency, result, single-cycle strobe.
  task automatic run_job(input string tag, input int x, input int y,
                         input int m_raw, input int m_cmp, input int z_exp);
    int lat;
    int m_exp;
    m_exp = COMP ? m_cmp : m_raw;
    @(negedge clk);
    x_in   = 8'(x);
    y_in   = 8'(y);
    stb_in = 1'b1;
    @(negedge clk);
    stb_in = 1'b0;
    check_eq({tag, "_busy_hi"}, int'(busy), 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (vld) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, "_latency"}, lat, LAT);
    check_eq({tag, "_mag"}, int'(mag), m_exp);
    check_eq({tag, "_z"}, int'(z), z_exp);
    check_eq({tag, "_busy_lo"}, int'(busy), 0);
    @(negedge clk);
    check_eq({tag, "_strobe_1cyc"}, int'(vld), 0);
  endtask

  initial begin
    int nvld;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    x_in     = '0;
    y_in     = '0;
    stb_in   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mag", int'(mag), 0);
    check_eq("rst_z", int'(z), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_vld", int'(vld), 0);
    rst = 1'b0;

    run_job("x64_y0", 64, 0, 106, 65, 1);

    // Asynchronous reset between edges clears outputs immediately
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_mag", int'(mag), 0);
    check_eq("async_rst_z", int'(z), 0);
    check_eq("async_rst_vld", int'(vld), 0);
    @(negedge clk);
    rst = 1'b0;

    run_job("x0_y64", 0, 64, 106, 65, 63);
    run_job("xm64_y0", -64, 0, 106, 65, 127);
    run_job("x127_y127", 127, 127, 297, 181, 33);
    run_job("xm128_ym128", -128, -128, 299, 182, -95);
    run_job("x64_ym64", 64, -64, 150, 91, -31);
    run_job("zero_vec", 0, 0, 0, 0, 0);

    // Strobes during CALC and during the OUTPUT cycle must be dropped
    @(negedge clk);
    x_in   = 8'sd64;
    y_in   = 8'sd0;
    stb_in = 1'b1;
    @(negedge clk);
    stb_in = 1'b0;
    nvld   = 0;
    for (int k = 1; k <= LAT + 6; k++) begin
      if (k == 3) begin
        x_in   = 8'sd0;
        y_in   = 8'sd64;
        stb_in = 1'b1;
      end else if (k == LAT) begin
        stb_in = 1'b1;
      end else begin
        stb_in = 1'b0;
      end
      @(negedge clk);
      if (k == 3) check_eq("ign_busy_calc", int'(busy), 1);
      if (vld) begin
        nvld++;
        check_eq("ign_mag", int'(mag), COMP ? 65 : 106);
        check_eq("ign_z", int'(z), 1);
      end
    end
    stb_in = 1'b0;
    check_eq("ign_strobe_count", nvld, 1);
    check_eq("ign_idle_after", int'(busy), 0);

    // Reset asserted mid-CALC aborts the job silently
    @(negedge clk);
    x_in   = 8'sd127;
    y_in   = 8'sd127;
    stb_in = 1'b1;
    @(negedge clk);
    stb_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_mag", int'(mag), 0);
    check_eq("abort_z", int'(z), 0);
    @(negedge clk);
    rst  = 1'b0;
    nvld = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (vld) nvld++;
    end
    check_eq("abort_no_strobe", nvld, 0);
    check_eq("abort_mag_hold", int'(mag), 0);

    run_job("after_abort", 0, 64, 106, 65, 63);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
